cpu_control_fsm: RTL and testbench
==================================

Name: cpu_control_fsm

Overview:
Multi-cycle control unit for the 8-bit accumulator-style core.
- Fetches one 8-bit instruction per pass, decodes it and drives the ALU control field and register-file read/write controls.
- Maintains the PC and a retired-instruction counter.
- Sits between instruction memory, register file and ALU; the ALU immediate input connects directly to ir[2:0].

Parameters:
PC_W, 8, program counter width; PC wraps modulo 2^PC_W
CNT_W, 16, retired-instruction counter width; wraps modulo 2^CNT_W

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  begin execution; sampled only in IDLE or HALT
imem_rdata  input  8  instruction word from instruction memory
imem_ack  input  1  imem_rdata valid this cycle; sampled only in FETCH
imem_req  output  1  fetch request; instruction address is pc
pc  output  PC_W  address of next instruction
ir  output  8  latched instruction {opcode[7:6], rd[5:3], imm[2:0]}
alu_ctrl  output  2  ALU operation select
rf_rd_addr  output  3  register-file read address (= ir[5:3])
rf_wr_addr  output  3  register-file write address (= ir[5:3])
rf_wr_en  output  1  register-file write strobe (ALU result is write data)
busy  output  1  high in FETCH, DECODE, EXEC, WB
halted  output  1  high in HALT
retired  output  CNT_W  count of completed instructions

Behaviour:
- Reset (async, immediate): state=IDLE, pc=0, ir=0, retired=0. Outputs: imem_req=0, rf_wr_en=0, alu_ctrl=2'b11, busy=0, halted=0.
- Reset mid-instruction: abandons the instruction; no rf_wr_en pulse may follow the reset edge.
- ISA decode of ir[7:6]:
  - 00 = LI rd,imm (ALU ctrl 00)
  - 01 = ADDI rd,imm (ALU ctrl 01; imm sign-extended by ALU)
  - 10 = NOP
  - 11 = HALT
- Outputs are decoded from registered state and ir only, with no combinational path from inputs to outputs.
- alu_ctrl=2'b11 (ALU outputs zero) in every state except EXEC/WB, where alu_ctrl=ir[7:6].
- rf_rd_addr and rf_wr_addr always equal ir[5:3].
- States and transitions:
  - IDLE: start=1 -> FETCH.
  - FETCH: imem_req=1. imem_ack=0 -> stay (unbounded wait, pc held).
    - imem_ack=1 -> ir<=imem_rdata, pc<=pc+1 (wraps 2^PC_W-1 -> 0), then DECODE.
  - DECODE: one cycle.
    - opcode 00/01 -> EXEC.
    - 10 -> retired+1, then FETCH.
    - 11 -> HALT (HALT is not counted as retired).
  - EXEC: one cycle for register read and ALU settle -> WB.
  - WB: rf_wr_en=1 for exactly this one cycle; retired+1 -> FETCH.
  - HALT: halted=1, busy=0. start=1 -> pc<=0, then FETCH.
- Input sampling rules:
  - start is ignored in all states other than IDLE/HALT.
  - imem_ack is ignored outside FETCH.
  - imem_rdata is latched only on the FETCH+ack cycle.
- Latency with imem_ack in the first FETCH cycle:
  - LI/ADDI: 4 cycles, FETCH to WB.
  - NOP: 2 cycles.
  - Each ack wait cycle adds 1 cycle.
- retired wraps silently at 2^CNT_W-1 -> 0.
- Exactly one write per LI/ADDI; none for NOP/HALT.

Test Plan:
- Reset, start=1 for one cycle, memory acks immediately with 0x0B (LI r1,3) -> imem_req in cycle 1; pc=1 after ack; rf_wr_en single pulse in cycle 4 with alu_ctrl=00, rf_wr_addr=1; retired=1.
- Follow with 0x4F (ADDI r1,-1) -> alu_ctrl=01 in EXEC and WB, rf_rd_addr=rf_wr_addr=1, one rf_wr_en pulse, pc=2, retired=2.
- Fetch 0x80 (NOP) then 0xC0 (HALT) -> no rf_wr_en; retired=3 after NOP; halted=1 and busy=0 after HALT; pc=4 and held; further start pulse -> pc=0, FETCH.
- Hold imem_ack=0 for 5 FETCH cycles, then ack 0x0B -> imem_req held high for 6 cycles, pc unchanged until ack, then normal 3-cycle completion; imem_ack pulses during EXEC are ignored.
- Preload pc=255 by running 255 NOPs, then fetch one more -> pc wraps to 0; retired=256.
- Assert rst during EXEC of an LI -> all outputs at reset values immediately; no rf_wr_en pulse; state IDLE; retired=0.

Source files
------------

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit for the 8-bit accumulator core: fetch, decode,
// execute and write-back sequencing with PC and retired-instruction tracking.
module cpu_control_fsm #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       imem_rdata,
    input  logic             imem_ack,
    output logic             imem_req,
    output logic [PC_W-1:0]  pc,
    output logic [7:0]       ir,
    output logic [1:0]       alu_ctrl,
    output logic [2:0]       rf_rd_addr,
    output logic [2:0]       rf_wr_addr,
    output logic             rf_wr_en,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] OP_LI    = 2'b00;
    localparam logic [1:0] OP_ADDI  = 2'b01;
    localparam logic [1:0] OP_NOP   = 2'b10;
    localparam logic [1:0] ALU_ZERO = 2'b11;

    state_t           state_reg, state_next;
    logic [PC_W-1:0]  pc_reg, pc_next;
    logic [7:0]       ir_reg, ir_next;
    logic [CNT_W-1:0] retired_reg, retired_next;
    logic [1:0]       opcode;

    assign opcode = ir_reg[7:6];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            pc_reg      <= '0;
            ir_reg      <= '0;
            retired_reg <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            ir_reg      <= ir_next;
            retired_reg <= retired_next;
        end
    end

    // Next-state and datapath updates; outputs depend only on registered state and ir.
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        ir_next      = ir_reg;
        retired_next = retired_reg;
        imem_req     = 1'b0;
        rf_wr_en     = 1'b0;
        busy         = 1'b0;
        halted       = 1'b0;
        alu_ctrl     = ALU_ZERO;

        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                busy     = 1'b1;
                if (imem_ack) begin
                    ir_next    = imem_rdata;
                    pc_next    = pc_reg + PC_W'(1);
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                busy = 1'b1;
                case (opcode)
                    OP_LI, OP_ADDI: state_next = S_EXEC;
                    OP_NOP: begin
                        retired_next = retired_reg + CNT_W'(1);
                        state_next   = S_FETCH;
                    end
                    default: state_next = S_HALT;
                endcase
            end
            S_EXEC: begin
                busy       = 1'b1;
                alu_ctrl   = opcode;
                state_next = S_WB;
            end
            S_WB: begin
                busy         = 1'b1;
                alu_ctrl     = opcode;
                rf_wr_en     = 1'b1;
                retired_next = retired_reg + CNT_W'(1);
                state_next   = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) begin
                    pc_next    = '0;
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign pc         = pc_reg;
    assign ir         = ir_reg;
    assign retired    = retired_reg;
    assign rf_rd_addr = ir_reg[5:3];
    assign rf_wr_addr = ir_reg[5:3];

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Randomized bench for cpu_control_fsm against an instruction-level model
// that tracks expected pc, retired count and per-cycle control strobes.
module tb_cpu_control_fsm;

    logic        clk = 1'b0;
    logic        rst, start, imem_ack;
    logic [7:0]  imem_rdata;
    logic        imem_req, rf_wr_en, busy, halted;
    logic [7:0]  pc, ir;
    logic [1:0]  alu_ctrl;
    logic [2:0]  rf_rd_addr, rf_wr_addr;
    logic [15:0] retired;

    int n_cmp = 0;
    int n_err = 0;
    int model_pc = 0;
    int model_ret = 0;

    cpu_control_fsm #(.PC_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .imem_rdata(imem_rdata),
        .imem_ack(imem_ack), .imem_req(imem_req), .pc(pc), .ir(ir),
        .alu_ctrl(alu_ctrl), .rf_rd_addr(rf_rd_addr), .rf_wr_addr(rf_wr_addr),
        .rf_wr_en(rf_wr_en), .busy(busy), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_rdata = 8'h00;
        tick(); tick();
        rst = 1'b0;
        model_pc = 0; model_ret = 0;
    endtask

    task automatic go_from_idle();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({imem_req, busy, halted} !== 3'b110 || pc !== 8'(model_pc)) begin
            n_err++;
            $display("FAIL start_fetch: req/busy/halted=%b pc=%0d, required 110 pc=%0d", {imem_req, busy, halted}, pc, model_pc);
        end
    endtask

    task automatic restart_from_halt();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_pc = 0;
        n_cmp++;
        if ({imem_req, busy, halted} !== 3'b110 || pc !== 8'd0) begin
            n_err++;
            $display("FAIL halt_restart: req/busy/halted=%b pc=%0d, required 110 pc=0", {imem_req, busy, halted}, pc);
        end
    endtask

    // Runs one instruction starting in FETCH, checking every cycle against the model.
    task automatic run_instr(input logic [7:0] instr, input int nwait);
        logic [1:0] op;
        op = instr[7:6];
        for (int i = 0; i <= nwait; i++) begin
            n_cmp++;
            if ({imem_req, busy, halted, rf_wr_en, alu_ctrl} !== 6'b110011 || pc !== 8'(model_pc)) begin
                n_err++;
                $display("FAIL fetch: req/busy/halt/wr/alu=%b pc=%0d, required 110011 pc=%0d", {imem_req, busy, halted, rf_wr_en, alu_ctrl}, pc, model_pc);
            end
            start = 1'($urandom_range(0, 1));
            imem_ack = (i == nwait);
            imem_rdata = (i == nwait) ? instr : 8'($urandom);
            tick();
        end
        imem_ack = 1'($urandom_range(0, 1));
        imem_rdata = 8'($urandom);
        model_pc = (model_pc + 1) % 256;
        n_cmp++;
        if ({imem_req, busy, halted, rf_wr_en, alu_ctrl} !== 6'b010011 || pc !== 8'(model_pc) || ir !== instr || rf_rd_addr !== instr[5:3]) begin
            n_err++;
            $display("FAIL decode: req/busy/halt/wr/alu=%b pc=%0d ir=%h rd=%0d, required 010011 pc=%0d ir=%h rd=%0d", {imem_req, busy, halted, rf_wr_en, alu_ctrl}, pc, ir, rf_rd_addr, model_pc, instr, instr[5:3]);
        end
        tick();
        if (op == 2'b00 || op == 2'b01) begin
            imem_ack = 1'($urandom_range(0, 1));
            n_cmp++;
            if ({imem_req, busy, halted, rf_wr_en} !== 4'b0100 || alu_ctrl !== op || rf_rd_addr !== instr[5:3]) begin
                n_err++;
                $display("FAIL exec: req/busy/halt/wr=%b alu=%b rd=%0d, required 0100 alu=%b rd=%0d", {imem_req, busy, halted, rf_wr_en}, alu_ctrl, rf_rd_addr, op, instr[5:3]);
            end
            tick();
            n_cmp++;
            if ({imem_req, busy, halted, rf_wr_en} !== 4'b0101 || alu_ctrl !== op || rf_wr_addr !== instr[5:3] || retired !== 16'(model_ret)) begin
                n_err++;
                $display("FAIL writeback: req/busy/halt/wr=%b alu=%b wa=%0d ret=%0d, required 0101 alu=%b wa=%0d ret=%0d", {imem_req, busy, halted, rf_wr_en}, alu_ctrl, rf_wr_addr, retired, op, instr[5:3], model_ret);
            end
            tick();
            model_ret = (model_ret + 1) % 65536;
        end
        imem_ack = 1'b0;
        start = 1'b0;
        if (op == 2'b11) begin
            n_cmp++;
            if ({imem_req, busy, halted, rf_wr_en, alu_ctrl} !== 6'b001011 || pc !== 8'(model_pc) || retired !== 16'(model_ret)) begin
                n_err++;
                $display("FAIL halt_enter: req/busy/halt/wr/alu=%b pc=%0d ret=%0d, required 001011 pc=%0d ret=%0d", {imem_req, busy, halted, rf_wr_en, alu_ctrl}, pc, retired, model_pc, model_ret);
            end
        end else begin
            if (op == 2'b10) model_ret = (model_ret + 1) % 65536;
            n_cmp++;
            if ({imem_req, busy, halted, rf_wr_en, alu_ctrl} !== 6'b110011 || retired !== 16'(model_ret)) begin
                n_err++;
                $display("FAIL next_fetch: req/busy/halt/wr/alu=%b ret=%0d, required 110011 ret=%0d", {imem_req, busy, halted, rf_wr_en, alu_ctrl}, retired, model_ret);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({imem_req, busy, halted, rf_wr_en, alu_ctrl} !== 6'b000011 || pc !== 8'd0 || ir !== 8'd0 || retired !== 16'd0) begin
                n_err++;
                $display("FAIL reset_idle: req/busy/halt/wr/alu=%b pc=%0d ir=%h ret=%0d, required 000011 0 00 0", {imem_req, busy, halted, rf_wr_en, alu_ctrl}, pc, ir, retired);
            end
            imem_ack = 1'b1;
            tick();
            imem_ack = 1'b0;
        end
    endtask

    task automatic test_li_addi();
        go_from_idle();
        run_instr(8'h0B, 0);
        n_cmp++;
        if (pc !== 8'd1 || retired !== 16'd1) begin
            n_err++;
            $display("FAIL li_result: pc=%0d ret=%0d, required pc=1 ret=1", pc, retired);
        end
        run_instr(8'h4F, 0);
        n_cmp++;
        if (pc !== 8'd2 || retired !== 16'd2) begin
            n_err++;
            $display("FAIL addi_result: pc=%0d ret=%0d, required pc=2 ret=2", pc, retired);
        end
    endtask

    task automatic test_nop_halt();
        run_instr(8'h80, 0);
        n_cmp++;
        if (retired !== 16'd3) begin
            n_err++;
            $display("FAIL nop_retired: ret=%0d, required 3", retired);
        end
        run_instr(8'hC0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (pc !== 8'd4 || halted !== 1'b1 || busy !== 1'b0 || retired !== 16'd3) begin
                n_err++;
                $display("FAIL halt_hold: pc=%0d halted=%b busy=%b ret=%0d, required pc=4 halted=1 busy=0 ret=3", pc, halted, busy, retired);
            end
        end
        restart_from_halt();
    endtask

    task automatic test_ack_wait();
        run_instr(8'h0B, 5);
    endtask

    task automatic test_pc_wrap();
        do_reset();
        go_from_idle();
        for (int i = 0; i < 255; i++) run_instr({2'b10, 6'($urandom)}, 0);
        n_cmp++;
        if (pc !== 8'd255 || retired !== 16'd255) begin
            n_err++;
            $display("FAIL pc_preload: pc=%0d ret=%0d, required pc=255 ret=255", pc, retired);
        end
        run_instr(8'h80, 0);
        n_cmp++;
        if (pc !== 8'd0 || retired !== 16'd256) begin
            n_err++;
            $display("FAIL pc_wrap: pc=%0d ret=%0d, required pc=0 ret=256", pc, retired);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        go_from_idle();
        imem_ack = 1'b1; imem_rdata = 8'h0B;
        tick();
        imem_ack = 1'b0;
        tick();
        n_cmp++;
        if (alu_ctrl !== 2'b00 || busy !== 1'b1 || rf_wr_en !== 1'b0) begin
            n_err++;
            $display("FAIL mid_exec: alu=%b busy=%b wr=%b, required alu=00 busy=1 wr=0", alu_ctrl, busy, rf_wr_en);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({imem_req, busy, halted, rf_wr_en, alu_ctrl} !== 6'b000011 || pc !== 8'd0 || ir !== 8'd0 || retired !== 16'd0) begin
            n_err++;
            $display("FAIL async_reset: req/busy/halt/wr/alu=%b pc=%0d ir=%h ret=%0d, required 000011 0 00 0", {imem_req, busy, halted, rf_wr_en, alu_ctrl}, pc, ir, retired);
        end
        tick();
        rst = 1'b0;
        model_pc = 0; model_ret = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (rf_wr_en !== 1'b0 || busy !== 1'b0 || retired !== 16'd0) begin
                n_err++;
                $display("FAIL post_reset: wr=%b busy=%b ret=%0d, required wr=0 busy=0 ret=0", rf_wr_en, busy, retired);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] instr;
        go_from_idle();
        for (int i = 0; i < 60; i++) begin
            instr = 8'($urandom);
            run_instr(instr, int'($urandom_range(0, 3)));
            if (instr[7:6] == 2'b11) restart_from_halt();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) run_instr({1'b0, 7'($urandom)}, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_rdata = 8'h00;
        test_reset();
        test_li_addi();
        test_nop_halt();
        test_ack_wait();
        test_back_to_back();
        test_pc_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
